// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, FSM states,
// requester ids and the per-transaction capture record.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Everything about the accepted request that the RESP cycle still needs.
    typedef struct packed {
        port_t      owner;
        logic       we;
        logic [1:0] size;
        logic [1:0] off;
        logic       err;
    } cap_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 4-lane memory: write enables, replicated store
// data, extracted/zero-extended load data and an alignment/size error flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rd_data,
    output logic [3:0]  byte_ctl,
    output logic [31:0] wr_data,
    output logic [31:0] rdata,
    output logic        misalign
);

    // Lane decode by size and low address bits; illegal size counts as misaligned.
    always_comb begin
        byte_ctl = 4'b0000;
        wr_data  = wdata;
        rdata    = 32'b0;
        misalign = 1'b0;
        case (size)
            SZ_WORD: begin
                misalign = (offset != 2'b00);
                byte_ctl = 4'b1111;
                rdata    = mem_rd_data;
            end
            SZ_HALF: begin
                misalign = offset[0];
                byte_ctl = offset[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{wdata[15:0]}};
                rdata    = {16'b0, (offset[1] ? mem_rd_data[31:16] : mem_rd_data[15:0])};
            end
            SZ_BYTE: begin
                byte_ctl = 4'b0001 << offset;
                wr_data  = {4{wdata[7:0]}};
                rdata    = {24'b0, mem_rd_data[{offset, 3'b000} +: 8]};
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port byte-lane data
// memory with one-cycle registered read. One transaction every 3 cycles:
// IDLE (handshake) -> ACCESS (memory samples) -> RESP (response pulse).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          c_req_valid,
    output logic          c_req_ready,
    input  logic          c_req_we,
    input  logic [1:0]    c_req_size,
    input  logic [AW-1:0] c_req_addr,
    input  logic [DW-1:0] c_req_wdata,
    output logic          c_rsp_valid,
    output logic [DW-1:0] c_rsp_rdata,
    output logic          c_rsp_err,

    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [1:0]    d_req_size,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_rdata,
    output logic          d_rsp_err,

    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic [3:0]    mem_byte_ctl,
    input  logic [DW-1:0] mem_rd_data
);

    state_t        state, state_nxt;
    port_t         last_grant;
    cap_t          cap;

    logic          grant_c, grant_d, hs;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [1:0]    al_size, al_off;
    logic [3:0]    al_ctl;
    logic [DW-1:0] al_wd, al_rd, rsp_data;
    logic          al_mis, rsp_fire;

    // Grant only in IDLE; on a tie the port that did not win last time goes.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (c_req_valid && d_req_valid) begin
                if (FIXED_PRIO != 0 || last_grant == PORT_D) grant_c = 1'b1;
                else                                         grant_d = 1'b1;
            end else begin
                grant_c = c_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    // Outputs are muted while reset is held so a reset landing in RESP shows no response.
    assign c_req_ready = grant_c & rst_n;
    assign d_req_ready = grant_d & rst_n;
    assign hs          = grant_c | grant_d;

    assign sel_we    = grant_d ? d_req_we    : c_req_we;
    assign sel_size  = grant_d ? d_req_size  : c_req_size;
    assign sel_addr  = grant_d ? d_req_addr  : c_req_addr;
    assign sel_wdata = grant_d ? d_req_wdata : c_req_wdata;

    // One aligner serves both directions: the live request in IDLE, the captured one after.
    assign al_size = (state == IDLE) ? sel_size       : cap.size;
    assign al_off  = (state == IDLE) ? sel_addr[1:0]  : cap.off;

    dmem_lane_align u_align (
        .size        (al_size),
        .offset      (al_off),
        .wdata       (sel_wdata),
        .mem_rd_data (mem_rd_data),
        .byte_ctl    (al_ctl),
        .wr_data     (al_wd),
        .rdata       (al_rd),
        .misalign    (al_mis)
    );

    // Next-state: handshake starts the fixed three-cycle sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture request and register memory controls; write strobe lasts only the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= PORT_D;
            cap          <= '0;
            mem_wr_en    <= 1'b0;
            mem_byte_ctl <= 4'b0000;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
        end else if (hs) begin
            last_grant   <= grant_d ? PORT_D : PORT_C;
            cap.owner    <= grant_d ? PORT_D : PORT_C;
            cap.we       <= sel_we;
            cap.size     <= sel_size;
            cap.off      <= sel_addr[1:0];
            cap.err      <= al_mis;
            mem_addr     <= sel_addr;
            mem_wr_data  <= al_wd;
            mem_wr_en    <= sel_we & ~al_mis;
            mem_byte_ctl <= (sel_we && !al_mis) ? al_ctl : 4'b0000;
        end else if (state == ACCESS) begin
            mem_wr_en    <= 1'b0;
            mem_byte_ctl <= 4'b0000;
        end
    end

    // Response steering: stores and errors return zero data.
    assign rsp_fire = (state == RESP) && rst_n;
    assign rsp_data = (cap.we || cap.err) ? '0 : al_rd;

    assign c_rsp_valid = rsp_fire && (cap.owner == PORT_C);
    assign d_rsp_valid = rsp_fire && (cap.owner == PORT_D);
    assign c_rsp_rdata = c_rsp_valid ? rsp_data : '0;
    assign d_rsp_rdata = d_rsp_valid ? rsp_data : '0;
    assign c_rsp_err   = c_rsp_valid & cap.err;
    assign d_rsp_err   = d_rsp_valid & cap.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-lane memory.
// A second instance with fixed priority shares the request inputs.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_err;
    logic [1:0]  c_req_size;
    logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic [3:0]  mem_byte_ctl;

    logic        f_c_req_ready, f_c_rsp_valid, f_c_rsp_err;
    logic        f_d_req_ready, f_d_rsp_valid, f_d_rsp_err;
    logic [31:0] f_c_rsp_rdata, f_d_rsp_rdata, f_mem_addr, f_mem_wr_data;
    logic        f_mem_wr_en;
    logic [3:0]  f_mem_byte_ctl;

    dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_size(c_req_size), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_size(d_req_size), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_byte_ctl(mem_byte_ctl), .mem_rd_data(mem_rd_data)
    );

    dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .c_req_valid(c_req_valid), .c_req_ready(f_c_req_ready), .c_req_we(c_req_we),
        .c_req_size(c_req_size), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_rsp_valid(f_c_rsp_valid), .c_rsp_rdata(f_c_rsp_rdata), .c_rsp_err(f_c_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(f_d_req_ready), .d_req_we(d_req_we),
        .d_req_size(d_req_size), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(f_d_rsp_valid), .d_rsp_rdata(f_d_rsp_rdata), .d_rsp_err(f_d_rsp_err),
        .mem_wr_en(f_mem_wr_en), .mem_addr(f_mem_addr), .mem_wr_data(f_mem_wr_data),
        .mem_byte_ctl(f_mem_byte_ctl), .mem_rd_data(mem_rd_data)
    );

    // Behavioural single-port memory, 64 words, registered read.
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (mem_wr_en)
            for (int i = 0; i < 4; i++)
                if (mem_byte_ctl[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wr_data[8*i +: 8];
        mem_rd_data <= mem[mem_addr[7:2]];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    logic [3:0]  acc_ctl;
    logic [31:0] acc_wd;
    logic        acc_we, wr_seen, other_rsp;

    function automatic logic rdy(input bit pd);
        return pd ? d_req_ready : c_req_ready;
    endfunction

    function automatic logic rspv(input bit pd);
        return pd ? d_rsp_valid : c_rsp_valid;
    endfunction

    task automatic drive(input bit pd, input bit v, input bit we, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (pd) begin
            d_req_valid = v; d_req_we = we; d_req_size = sz; d_req_addr = ad; d_req_wdata = wd;
        end else begin
            c_req_valid = v; c_req_we = we; c_req_size = sz; c_req_addr = ad; c_req_wdata = wd;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the ACCESS cycle.
    task automatic start_req(input bit pd, input bit we, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd);
        int n;
        logic ok;
        drive(pd, 1'b1, we, sz, ad, wd);
        #1;
        n = 0;
        while (!rdy(pd) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = rdy(pd);
        chk("handshake", ok, 1);
        @(posedge clk); #1;
        drive(pd, 1'b0, we, sz, ad, wd);
        acc_ctl = mem_byte_ctl;
        acc_wd  = mem_wr_data;
        acc_we  = mem_wr_en;
        wr_seen = mem_wr_en;
    endtask

    task automatic xact(input bit pd, input bit we, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        start_req(pd, we, sz, ad, wd);
        lat = 1;
        other_rsp = rspv(!pd);
        while (!rspv(pd) && lat < 8) begin
            @(posedge clk); #1; lat++;
            wr_seen   = wr_seen | mem_wr_en;
            other_rsp = other_rsp | rspv(!pd);
        end
        rd = pd ? d_rsp_rdata : c_rsp_rdata;
        er = pd ? d_rsp_err : c_rsp_err;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, rsp_cnt, g0, g1;
    logic [3:0]  seq0, seq1;

    initial begin
        drive(1'b0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_byte_ctl", mem_byte_ctl, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_rsp", {c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err}, 0);
        chk("rst_rdata", c_rsp_rdata | d_rsp_rdata, 0);
        c_req_valid = 1'b1;
        #1;
        chk("rst_ready", {c_req_ready, d_req_ready}, 0);
        c_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // byte store 0xA5 at 0x13
        xact(1'b0, 1'b1, SZ_BYTE, 32'h13, 32'hA5, rd, er, lat);
        chk("bst_ctl", acc_ctl, 4'b1000);
        chk("bst_wd", acc_wd, 32'hA5A5A5A5);
        chk("bst_we", acc_we, 1);
        chk("bst_rsp", {rd, er}, 0);
        chk("bst_lat", lat, 2);
        chk("bst_other", other_rsp, 0);

        // word store from C, half load from D
        xact(1'b0, 1'b1, SZ_WORD, 32'h20, 32'h11223344, rd, er, lat);
        chk("wst_ctl", acc_ctl, 4'b1111);
        xact(1'b1, 1'b0, SZ_HALF, 32'h22, 32'h0, rd, er, lat);
        chk("hld_rdata", rd, 32'h00001122);
        chk("hld_err", er, 0);
        chk("hld_lat", lat, 2);
        chk("hld_other", other_rsp, 0);
        xact(1'b0, 1'b0, SZ_BYTE, 32'h13, 32'h0, rd, er, lat);
        chk("bld_rdata", rd, 32'h000000A5);

        // error cases
        xact(1'b0, 1'b0, SZ_WORD, 32'h21, 32'h0, rd, er, lat);
        chk("mis_word_err", er, 1);
        chk("mis_word_rd", rd, 0);
        chk("mis_word_wr", wr_seen, 0);
        xact(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, rd, er, lat);
        chk("bad_size_err", er, 1);
        xact(1'b0, 1'b1, SZ_HALF, 32'h01, 32'hFFFF, rd, er, lat);
        chk("mis_hst_err", er, 1);
        chk("mis_hst_wr", wr_seen, 0);
        chk("mis_hst_ctl", acc_ctl, 0);
        xact(1'b0, 1'b0, SZ_WORD, 32'h00, 32'h0, rd, er, lat);
        chk("mis_hst_mem", rd, 32'h0);

        // upper half store merges into existing word
        xact(1'b0, 1'b1, SZ_WORD, 32'h04, 32'h12345678, rd, er, lat);
        xact(1'b1, 1'b1, SZ_HALF, 32'h06, 32'hBEEF, rd, er, lat);
        chk("hst_ctl", acc_ctl, 4'b1100);
        chk("hst_wd", acc_wd, 32'hBEEFBEEF);
        chk("hst_rsp", {rd, er}, 0);
        xact(1'b1, 1'b0, SZ_WORD, 32'h04, 32'h0, rd, er, lat);
        chk("hst_merge", rd, 32'hBEEF5678);

        // reset while in RESP
        start_req(1'b0, 1'b0, SZ_WORD, 32'h20, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rresp_rsp", c_rsp_valid | d_rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0);
        #1;
        chk("rresp_idle", c_req_ready, 1);
        chk("rresp_rsp2", c_rsp_valid | d_rsp_valid, 0);
        c_req_valid = 1'b0;
        @(posedge clk); #1;

        // reset while a store is in ACCESS
        start_req(1'b0, 1'b1, SZ_WORD, 32'h30, 32'hCAFEF00D);
        chk("racc_we", acc_we, 1);
        rst_n = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            if (c_rsp_valid || d_rsp_valid) rsp_cnt++;
        end
        chk("racc_rsp", rsp_cnt, 0);
        xact(1'b0, 1'b0, SZ_WORD, 32'h30, 32'h0, rd, er, lat);
        chk("racc_mem", rd, 32'hCAFEF00D);

        // contention from reset: round-robin vs fixed priority
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0);
        drive(1'b1, 1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0);
        g0 = 0; g1 = 0; seq0 = 4'hF; seq1 = 4'hF;
        for (int i = 0; i < 40 && (g0 < 4 || g1 < 4); i++) begin
            #1;
            if (g0 < 4 && (c_req_ready || d_req_ready)) begin
                seq0[g0] = d_req_ready; g0++;
            end
            if (g1 < 4 && (f_c_req_ready || f_d_req_ready)) begin
                seq1[g1] = f_d_req_ready; g1++;
            end
            @(posedge clk); #1;
        end
        c_req_valid = 1'b0;
        d_req_valid = 1'b0;
        chk("rr_cnt", g0, 4);
        chk("rr_seq", seq0, 4'b1010);
        chk("fp_cnt", g1, 4);
        chk("fp_seq", seq1, 4'b0000);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
